// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
//   Load channel between a value producer and seg7_scan_driver.
//
//   Handshake: the producer raises `load` for exactly one cycle with `data`/`dp`
//   valid in that same cycle. The driver always accepts it, so there is no
//   ready. `load_ack` pulses for one cycle when a captured value is shown on
//   the display, which happens at the next frame wrap. Several loads before a
//   wrap collapse into one value and produce one ack.
//
//   Signals
//     data      16  four nibbles, digit n = data[4n+3:4n]
//     dp        4   decimal point per digit, 1 = lit
//     load      1   one-cycle capture strobe
//     load_ack  1   one-cycle pulse when the pending value becomes active
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        load;
    logic        load_ack;

    modport master (
        output data,
        output dp,
        output load,
        input  load_ack
    );

    modport slave (
        input  data,
        input  dp,
        input  load,
        output load_ack
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Drives a 4-digit common-anode 7-segment display from the sel/digi outputs
//   of a digit-scan FSM. The displayed value is double buffered: a load goes
//   into a pending register and only becomes active at a frame wrap
//   (sel going 3 -> 0), so one frame never mixes old and new digits.
//   Leading-zero blanking and PWM brightness on the anodes are provided.
//   Every output is registered; inputs at one edge show on the outputs
//   after that edge.
//
//   Ports
//     clk         in   1         system clock
//     rst_ni      in   1         synchronous reset, active low
//     sel_i       in   2         digit index from scan FSM (0 = rightmost)
//     digi_i      in   [4:1]     one-hot digit enable, active high
//     bus         if   slave     data/dp/load in, load_ack out
//     bright_i    in   BRIGHT_W  anode duty, lit while pwm_cnt < bright_i
//     blank_lz_i  in   1         1 = blank leading zero digits
//     seg_o       out  7         segments g..a = [6:0], active low
//     dp_o        out  1         decimal point, active low
//     an_o        out  [4:1]     anodes, active low
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int BRIGHT_W = 4
) (
    input  logic                clk,
    input  logic                rst_ni,
    input  logic [1:0]          sel_i,
    input  logic [4:1]          digi_i,
    seg7_scan_driver_if.slave   bus,
    input  logic [BRIGHT_W-1:0] bright_i,
    input  logic                blank_lz_i,
    output logic [6:0]          seg_o,
    output logic                dp_o,
    output logic [4:1]          an_o
);

    // Segment glyphs, bit order g..a, a lit segment is 0.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    logic [1:0]          r_prev_sel;
    logic [15:0]         r_pend_data;
    logic [3:0]          r_pend_dp;
    logic                r_pend_v;
    logic [15:0]         r_act_data;
    logic [3:0]          r_act_dp;
    logic                r_ack;
    logic [BRIGHT_W-1:0] r_pwm_cnt;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [4:1]          r_an;

    logic        w_wrap;
    logic        w_swap;
    logic [15:0] w_cur_data;
    logic [3:0]  w_cur_dp;
    logic [3:0]  w_nib;
    logic [3:0]  w_lz;
    logic        w_blank;
    logic        w_pwm_on;
    logic        w_scan_ok;
    logic [6:0]  w_seg;
    logic        w_dp;
    logic [4:1]  w_an;

    assign w_wrap = (r_prev_sel == 2'd3) && (sel_i == 2'd0);
    assign w_swap = w_wrap && r_pend_v;

    // On the wrap cycle the digit being registered is the first of the new
    // frame, so it is taken from the value that becomes active at this edge.
    assign w_cur_data = w_swap ? r_pend_data : r_act_data;
    assign w_cur_dp   = w_swap ? r_pend_dp   : r_act_dp;

    assign w_nib = w_cur_data[{sel_i, 2'b00} +: 4];

    // w_lz[k]: digit k and every digit above it are zero. Digit 0 never blanks.
    always_comb begin
        w_lz    = 4'b0000;
        w_lz[3] = (w_cur_data[15:12] == 4'h0);
        w_lz[2] = w_lz[3] && (w_cur_data[11:8] == 4'h0);
        w_lz[1] = w_lz[2] && (w_cur_data[7:4] == 4'h0);
    end

    assign w_blank   = blank_lz_i && w_lz[sel_i];
    assign w_seg     = w_blank ? 7'h7F : hex_glyph(w_nib);
    assign w_dp      = ~w_cur_dp[sel_i];
    assign w_pwm_on  = (r_pwm_cnt < bright_i);

    // A digit enable that disagrees with sel (not one-hot, or the wrong bit)
    // darkens every anode for that cycle rather than lighting a wrong digit.
    assign w_scan_ok = (digi_i == (4'b0001 << sel_i));
    assign w_an      = w_scan_ok ? ~(digi_i & {4{w_pwm_on}}) : 4'hF;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            r_prev_sel  <= 2'd0;
            r_pend_data <= 16'h0000;
            r_pend_dp   <= 4'h0;
            r_pend_v    <= 1'b0;
            r_act_data  <= 16'h0000;
            r_act_dp    <= 4'h0;
            r_ack       <= 1'b0;
            r_pwm_cnt   <= '0;
            r_seg       <= 7'h7F;
            r_dp        <= 1'b1;
            r_an        <= 4'hF;
        end else begin
            r_prev_sel <= sel_i;
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
            r_ack      <= w_swap;

            // Transfer reads the old pending value; a load in the same cycle
            // refills pending and keeps it valid.
            if (w_swap) begin
                r_act_data <= r_pend_data;
                r_act_dp   <= r_pend_dp;
            end
            if (bus.load) begin
                r_pend_data <= bus.data;
                r_pend_dp   <= bus.dp;
                r_pend_v    <= 1'b1;
            end else if (w_swap) begin
                r_pend_v <= 1'b0;
            end

            r_seg <= w_seg;
            r_dp  <= w_dp;
            r_an  <= w_an;
        end
    end

    assign seg_o        = r_seg;
    assign dp_o         = r_dp;
    assign an_o         = r_an;
    assign bus.load_ack = r_ack;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    logic       clk;
    logic       rst_ni;
    logic [1:0] sel;
    logic [4:1] digi;
    logic [3:0] bright;
    logic       blank_lz;
    logic [6:0] seg;
    logic       dp;
    logic [4:1] an;

    int n_total;
    int n_bad;

    // bench-side expectation of anodes, from a free-running PWM count model
    logic [3:0] m_cnt;
    logic [4:1] m_an;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.BRIGHT_W(4)) dut (
        .clk        (clk),
        .rst_ni     (rst_ni),
        .sel_i      (sel),
        .digi_i     (digi),
        .bus        (bus),
        .bright_i   (bright),
        .blank_lz_i (blank_lz),
        .seg_o      (seg),
        .dp_o       (dp),
        .an_o       (an)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock: update anode model from the inputs seen at this edge, then
    // sample outputs 1 ns after the edge
    task automatic step();
        logic on;
        on = (m_cnt < bright);
        if (!rst_ni) begin
            m_an  = 4'hF;
            m_cnt = 4'd0;
        end else begin
            if (digi == (4'b0001 << sel)) m_an = ~(digi & {4{on}});
            else                          m_an = 4'hF;
            m_cnt = m_cnt + 4'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [1:0] s);
        sel  = s;
        digi = 4'b0001 << s;
        step();
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        bus.load = 1'b1;
        bus.data = d;
        bus.dp   = p;
    endtask

    task automatic unload();
        bus.load = 1'b0;
    endtask

    task automatic expect_digit(input string tag, input logic [6:0] s, input logic d, input logic a);
        check({tag, ".seg"}, 16'(seg), 16'(s));
        check({tag, ".dp"},  16'(dp),  16'(d));
        check({tag, ".ack"}, 16'(bus.load_ack), 16'(a));
        check({tag, ".an"},  16'(an),  16'(m_an));
    endtask

    initial begin
        int lows;
        n_total  = 0;
        n_bad    = 0;
        m_cnt    = 4'd0;
        m_an     = 4'hF;
        rst_ni   = 1'b0;
        sel      = 2'd0;
        digi     = 4'b0001;
        bright   = 4'hF;
        blank_lz = 1'b0;
        bus.load = 1'b0;
        bus.data = 16'h0;
        bus.dp   = 4'h0;

        // 1: reset
        step();
        step();
        check("rst.seg", 16'(seg), 16'h7F);
        check("rst.dp",  16'(dp),  16'h1);
        check("rst.an",  16'(an),  16'hF);
        check("rst.ack", 16'(bus.load_ack), 16'h0);
        rst_ni = 1'b1;

        // 2: load 12AF, shown from the next wrap; old frame shows zeros
        load(16'h12AF, 4'b0101);
        scan(2'd0);
        unload();
        expect_digit("t2.pre0", 7'h40, 1'b1, 1'b0);
        scan(2'd1); expect_digit("t2.pre1", 7'h40, 1'b1, 1'b0);
        scan(2'd2); expect_digit("t2.pre2", 7'h40, 1'b1, 1'b0);
        scan(2'd3); expect_digit("t2.pre3", 7'h40, 1'b1, 1'b0);
        scan(2'd0); expect_digit("t2.d0", 7'h0E, 1'b0, 1'b1);
        scan(2'd1); expect_digit("t2.d1", 7'h08, 1'b1, 1'b0);
        scan(2'd2); expect_digit("t2.d2", 7'h24, 1'b0, 1'b0);
        scan(2'd3); expect_digit("t2.d3", 7'h79, 1'b1, 1'b0);

        // 3: two loads before a wrap -> one ack, leading zeros blanked
        blank_lz = 1'b1;
        load(16'h0000, 4'h0); scan(2'd1);
        load(16'h0042, 4'h0); scan(2'd2);
        unload();
        scan(2'd3); expect_digit("t3.old3", 7'h79, 1'b1, 1'b0);
        scan(2'd0); expect_digit("t3.d0", 7'h24, 1'b1, 1'b1);
        scan(2'd1); expect_digit("t3.d1", 7'h19, 1'b1, 1'b0);
        scan(2'd2); expect_digit("t3.d2", 7'h7F, 1'b1, 1'b0);
        scan(2'd3); expect_digit("t3.d3", 7'h7F, 1'b1, 1'b0);
        scan(2'd0); expect_digit("t3.noack", 7'h24, 1'b1, 1'b0);

        // 4: load on the wrap cycle while a value is pending
        blank_lz = 1'b0;
        load(16'h3333, 4'h0); scan(2'd1);
        unload();
        scan(2'd2);
        scan(2'd3);
        load(16'h5555, 4'hF); scan(2'd0);
        unload();
        expect_digit("t4.w1d0", 7'h30, 1'b1, 1'b1);
        scan(2'd1); expect_digit("t4.w1d1", 7'h30, 1'b1, 1'b0);
        scan(2'd2); expect_digit("t4.w1d2", 7'h30, 1'b1, 1'b0);
        scan(2'd3); expect_digit("t4.w1d3", 7'h30, 1'b1, 1'b0);
        scan(2'd0); expect_digit("t4.w2d0", 7'h12, 1'b0, 1'b1);
        scan(2'd1); expect_digit("t4.w2d1", 7'h12, 1'b0, 1'b0);

        // 5: PWM duty on a fixed digit
        bright = 4'd4;
        scan(2'd0);
        lows = 0;
        for (int i = 0; i < 32; i++) begin
            scan(2'd0);
            if (an[1] == 1'b0) lows++;
            check("t5.an_model", 16'(an), 16'(m_an));
        end
        check("t5.lows", 16'(lows), 16'd8);
        bright = 4'd0;
        scan(2'd0);
        lows = 0;
        for (int i = 0; i < 16; i++) begin
            scan(2'd0);
            if (an != 4'hF) lows++;
        end
        check("t5.dark", 16'(lows), 16'd0);

        // 6: scan checks and reset while pending
        bright = 4'hF;
        sel = 2'd0; digi = 4'b0011; step();
        check("t6.multi", 16'(an), 16'hF);
        sel = 2'd2; digi = 4'b0001; step();
        check("t6.mism", 16'(an), 16'hF);
        load(16'h7777, 4'hF); scan(2'd1);
        unload();
        rst_ni = 1'b0; step();
        check("t6.rst.seg", 16'(seg), 16'h7F);
        check("t6.rst.an",  16'(an),  16'hF);
        rst_ni = 1'b1;
        scan(2'd1);
        scan(2'd2);
        scan(2'd3); expect_digit("t6.d3", 7'h40, 1'b1, 1'b0);
        scan(2'd0); expect_digit("t6.d0", 7'h40, 1'b1, 1'b0);
        scan(2'd1); expect_digit("t6.d1", 7'h40, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
